player_position: RTL and testbench



---
 rtl/player_pkg.sv | 33 +++
 rtl/player_position_kick_timer.sv | 67 ++++++
 rtl/player_position.sv | 140 ++++++++++++++
 tb/tb_player_position.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types, arena geometry and saturating position arithmetic for the player motion logic.
package player_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 64;
  localparam int POS_W    = 11;

  localparam int X_MAX_DEF    = SCREEN_W - SPRITE_W;
  localparam int Y_GROUND_DEF = SCREEN_H - SPRITE_H;

  typedef enum logic [1:0] {GROUND, RISE, FALL} vstate_e;
  typedef enum logic [1:0] {K_IDLE, K_ACTIVE, K_COOL} kstate_e;

  // Position is unsigned, delta is two's complement; both widened to 12 bits before the add.
  function automatic logic signed [POS_W:0] add_delta(input logic [POS_W-1:0] pos,
                                                      input logic [POS_W-1:0] delta);
    return $signed({1'b0, pos} + {delta[POS_W-1], delta});
  endfunction

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [POS_W:0] sum,
                                                 input logic [POS_W-1:0]      lo,
                                                 input logic [POS_W-1:0]      hi);
    if (sum < $signed({1'b0, lo})) begin
      return lo;
    end else if (sum > $signed({1'b0, hi})) begin
      return hi;
    end
    return sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/player_position_kick_timer.sv
// Kick window timer: KICK_FRAMES ticks active, then KICK_COOLDOWN ticks in which requests are ignored.
// Advances only on frame_tick; kick_active is registered state, visible the cycle after the tick.
module kick_timer
  import player_pkg::*;
#(
  parameter int KICK_FRAMES   = 8,
  parameter int KICK_COOLDOWN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic kickon,
  output logic kick_active
);

  localparam int CW = 8;

  kstate_e       state_q, state_d;
  logic [CW-1:0] kcnt_q, kcnt_d;

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    if (frame_tick) begin
      unique case (state_q)
        K_IDLE: begin
          if (kickon) begin
            state_d = K_ACTIVE;
            kcnt_d  = CW'(KICK_FRAMES - 1);
          end
        end
        K_ACTIVE: begin
          if (kcnt_q == '0) begin
            state_d = K_COOL;
            kcnt_d  = CW'(KICK_COOLDOWN - 1);
          end else begin
            kcnt_d = kcnt_q - 1'b1;
          end
        end
        K_COOL: begin
          if (kcnt_q == '0) begin
            state_d = K_IDLE;
          end else begin
            kcnt_d = kcnt_q - 1'b1;
          end
        end
        default: begin
          state_d = K_IDLE;
          kcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= K_IDLE;
      kcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
    end
  end

  assign kick_active = (state_q == K_ACTIVE);

endmodule

// File: rtl/player_position.sv
// Per-frame player motion integrator: arena clamping, jump-height limiting and kick-freeze of x.
// All state advances on frame_tick only; outputs are registered (one cycle after the tick edge).
module player_position
  import player_pkg::*;
#(
  parameter int X_MIN         = 0,
  parameter int X_MAX         = X_MAX_DEF,
  parameter int Y_MIN         = 0,
  parameter int Y_GROUND      = Y_GROUND_DEF,
  parameter int X_INIT        = 100,
  parameter int RISE_FRAMES   = 12,
  parameter int KICK_FRAMES   = 8,
  parameter int KICK_COOLDOWN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic [POS_W-1:0]  dx,
  input  logic [POS_W-1:0]  dy,
  input  logic              kickon,
  output logic [POS_W-1:0]  pos_x,
  output logic [POS_W-1:0]  pos_y,
  output logic              on_ground,
  output logic              kick_active,
  output logic              facing_left
);

  localparam logic [POS_W-1:0]        X_LO     = POS_W'(X_MIN);
  localparam logic [POS_W-1:0]        X_HI     = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]        Y_LO     = POS_W'(Y_MIN);
  localparam logic [POS_W-1:0]        Y_HI     = POS_W'(Y_GROUND);
  localparam logic signed [POS_W:0]   Y_LO_S   = (POS_W+1)'(Y_MIN);
  localparam logic signed [POS_W:0]   Y_HI_S   = (POS_W+1)'(Y_GROUND);
  localparam logic [7:0]              RISE_LIM = 8'(RISE_FRAMES);

  logic [POS_W-1:0]      pos_x_q, pos_x_d;
  logic [POS_W-1:0]      pos_y_q, pos_y_d;
  vstate_e               vstate_q, vstate_d;
  logic [7:0]            rise_cnt_q, rise_cnt_d;
  logic                  facing_left_q, facing_left_d;

  logic [POS_W-1:0]      dx_eff;
  logic [POS_W-1:0]      dy_fall;
  logic signed [POS_W:0] sum_x;
  logic signed [POS_W:0] sum_y;
  logic signed [POS_W:0] sum_fall;

  kick_timer #(
    .KICK_FRAMES   (KICK_FRAMES),
    .KICK_COOLDOWN (KICK_COOLDOWN)
  ) u_kick_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .kickon      (kickon),
    .kick_active (kick_active)
  );

  always_comb begin
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    vstate_d      = vstate_q;
    rise_cnt_d    = rise_cnt_q;
    facing_left_d = facing_left_q;

    // The player is rooted while the kick animation plays.
    dx_eff   = kick_active ? '0 : dx;
    dy_fall  = dy[POS_W-1] ? '0 : dy;
    sum_x    = add_delta(pos_x_q, dx_eff);
    sum_y    = add_delta(pos_y_q, dy);
    sum_fall = add_delta(pos_y_q, dy_fall);

    if (frame_tick) begin
      pos_x_d = clamp_pos(sum_x, X_LO, X_HI);
      if (dx_eff[POS_W-1]) begin
        facing_left_d = 1'b1;
      end else if (dx_eff != '0) begin
        facing_left_d = 1'b0;
      end

      unique case (vstate_q)
        GROUND: begin
          if (dy[POS_W-1]) begin
            pos_y_d    = clamp_pos(sum_y, Y_LO, Y_HI);
            vstate_d   = RISE;
            rise_cnt_d = 8'd1;
          end
        end
        RISE: begin
          if (dy[POS_W-1] && (rise_cnt_q < RISE_LIM)) begin
            pos_y_d    = clamp_pos(sum_y, Y_LO, Y_HI);
            rise_cnt_d = rise_cnt_q + 8'd1;
            // Hitting the ceiling ends the ascent immediately.
            if (sum_y < Y_LO_S) begin
              vstate_d   = FALL;
              rise_cnt_d = '0;
            end
          end else begin
            pos_y_d    = clamp_pos(sum_fall, Y_LO, Y_HI);
            vstate_d   = FALL;
            rise_cnt_d = '0;
          end
        end
        FALL: begin
          pos_y_d = clamp_pos(sum_fall, Y_LO, Y_HI);
          if (sum_fall >= Y_HI_S) begin
            vstate_d = GROUND;
          end
        end
        default: begin
          vstate_d   = GROUND;
          pos_y_d    = Y_HI;
          rise_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q       <= POS_W'(X_INIT);
      pos_y_q       <= Y_HI;
      vstate_q      <= GROUND;
      rise_cnt_q    <= '0;
      facing_left_q <= 1'b0;
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vstate_q      <= vstate_d;
      rise_cnt_q    <= rise_cnt_d;
      facing_left_q <= facing_left_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign on_ground   = (vstate_q == GROUND);
  assign facing_left = facing_left_q;

endmodule

// File: tb/tb_player_position.sv
// Randomized and directed stimulus for player_position, checked by a queue-based scoreboard
// against a frame-level behavioural model of the player.
module tb_player_position;

  localparam int XMAX = 608;
  localparam int YGND = 416;
  localparam int XINI = 100;
  localparam int RISE = 12;
  localparam int KF   = 8;
  localparam int KC   = 16;

  typedef struct {
    int x;
    int y;
    bit g;
    bit k;
    bit f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [10:0] dx = '0;
  logic [10:0] dy = '0;
  logic        kickon = 1'b0;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        on_ground;
  logic        kick_active;
  logic        facing_left;

  player_position dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .dx          (dx),
    .dy          (dy),
    .kickon      (kickon),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .on_ground   (on_ground),
    .kick_active (kick_active),
    .facing_left (facing_left)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;
  logic tick_seen = 1'b0;

  always @(posedge clk) tick_seen <= frame_tick;

  // Frame-level model: height phase 0=standing, 1=ascending, 2=descending; kick age counts ticks since kick start.
  int m_x, m_y, m_phase, m_up, m_age;
  bit m_face;

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_x = XINI; m_y = YGND; m_phase = 0; m_up = 0; m_age = -1; m_face = 1'b0;
  endtask

  task automatic model_step(input int vdx, input int vdy, input bit vk);
    bit kicking;
    int edx, s;
    kicking = (m_age >= 0) && (m_age < KF);
    edx = kicking ? 0 : vdx;
    m_x = clampi(m_x + edx, 0, XMAX);
    if (edx < 0) m_face = 1'b1;
    else if (edx > 0) m_face = 1'b0;

    if (m_phase == 0) begin
      if (vdy < 0) begin
        m_y = clampi(m_y + vdy, 0, YGND);
        m_phase = 1;
        m_up = 1;
      end
    end else if (m_phase == 1) begin
      if (vdy < 0 && m_up < RISE) begin
        s = m_y + vdy;
        m_up++;
        if (s < 0) begin
          m_y = 0;
          m_phase = 2;
        end else begin
          m_y = s;
        end
      end else begin
        m_phase = 2;
        if (vdy >= 0) m_y = clampi(m_y + vdy, 0, YGND);
      end
    end else begin
      s = m_y + ((vdy > 0) ? vdy : 0);
      if (s >= YGND) begin
        m_y = YGND;
        m_phase = 0;
      end else begin
        m_y = s;
      end
    end

    if (m_age < 0) begin
      if (vk) m_age = 0;
    end else begin
      m_age++;
      if (m_age == KF + KC) m_age = -1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.x = m_x; e.y = m_y; e.g = (m_phase == 0);
    e.k = (m_age >= 0) && (m_age < KF);
    e.f = m_face;
    return e;
  endfunction

  task automatic tick(input int vdx, input int vdy, input bit vk, input int gap);
    model_step(vdx, vdy, vk);
    q.push_back(model_out());
    @(negedge clk);
    dx = 11'(vdx);
    dy = 11'(vdy);
    kickon = vk;
    frame_tick = 1'b1;
    if (gap > 0) begin
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  function automatic int rnd_delta(input int neg_bias);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < neg_bias) return -int'($urandom_range(1, 20));
    if (r < 8) return int'($urandom_range(0, 20));
    return int'($urandom_range(0, 2046)) - 1023;
  endfunction

  // Scoreboard monitor: the only process that counts comparisons.
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string ctx, input exp_t e);
    chk({ctx, ".pos_x"}, int'(pos_x), e.x);
    chk({ctx, ".pos_y"}, int'(pos_y), e.y);
    chk({ctx, ".on_ground"}, int'(on_ground), int'(e.g));
    chk({ctx, ".kick_active"}, int'(kick_active), int'(e.k));
    chk({ctx, ".facing_left"}, int'(facing_left), int'(e.f));
  endtask

  initial begin
    exp_t cur, rst_e;
    rst_e.x = XINI; rst_e.y = YGND; rst_e.g = 1'b1; rst_e.k = 1'b0; rst_e.f = 1'b0;
    cur = rst_e;
    forever begin
      @(negedge clk or negedge rst_n or posedge done);
      #1;
      if (done) begin
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      if (!rst_n) begin
        cmp_all("reset", rst_e);
        q.delete();
        cur = rst_e;
      end else if (tick_seen) begin
        if (q.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          cur = q.pop_front();
          cmp_all("tick", cur);
        end
      end else begin
        cmp_all("hold", cur);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Walk right on the floor; positive dy keeps the player grounded.
    for (int i = 0; i < 10; i++) tick(1, 5, 1'b0, int'($urandom_range(1, 2)));

    // Full jump: 12 rising frames, then hold, then fall back to the floor.
    for (int i = 0; i < 20; i++) tick(0, -5, 1'b0, 1);
    for (int i = 0; i < 12; i++) tick(0, 5, 1'b0, 1);

    // Left and right arena edges.
    tick(2 - m_x, 0, 1'b0, 1);
    for (int i = 0; i < 5; i++) tick(-1, 0, 1'b0, 1);
    tick(607 - m_x, 0, 1'b0, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 1'b0, 1);

    // Held kick request with back-to-back ticks.
    tick(300 - m_x, 0, 1'b0, 1);
    for (int i = 0; i < 40; i++) tick(1, 0, 1'b1, (i == 39) ? 1 : 0);

    // Ceiling clamp during the ascent.
    tick(0, -413, 1'b0, 1);
    tick(0, -5, 1'b0, 1);
    tick(0, -5, 1'b0, 1);
    tick(0, 0, 1'b0, 1);
    for (int i = 0; i < 9; i++) tick(0, 50, 1'b0, 1);

    // Randomized play.
    for (int i = 0; i < 500; i++) begin
      tick(rnd_delta(3), rnd_delta(4), ($urandom_range(0, 4) == 0),
           (i == 499) ? 1 : int'($urandom_range(0, 2)));
    end

    // Asynchronous reset mid-jump with the kick window open.
    for (int i = 0; i < 30; i++) tick(0, 20, 1'b0, 1);
    tick(3, -5, 1'b1, 1);
    tick(0, -5, 1'b0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(-2, -3, 1'b1, 1);

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule
